// File: rtl/send_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// send_pkg
// Shared types and helpers for the send-channel arbiter.
//   state_t  : transfer sequencer states (3-bit encoding)
//   SYM_W    : width of one channel symbol
//   next_ptr : round-robin pointer advance with wrap
// ---------------------------------------------------------------------------
package send_pkg;

  localparam int SYM_W = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    SETUP   = 3'd2,
    SEND    = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5,
    ABORT   = 3'd6
  } state_t;

  // The requester after idx gets first look next time; wraps n-1 back to 0.
  function automatic int next_ptr(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/send_arbiter_if.sv
// ---------------------------------------------------------------------------
// send_arbiter_if
// Bundles the requester side and the receiver side of the shared channel.
//   req    : per-requester transfer request (level)
//   sym    : per-requester symbol, sym[2i+1:2i] belongs to requester i
//   gnt    : one-hot grant for the whole transfer
//   done   : one-cycle successful-completion pulse per requester
//   err    : one-cycle timeout-abort pulse per requester
//   busy   : arbiter not idle
//   ack    : receiver acknowledge
//   bit0/1 : channel symbol LSB/MSB
//   Dt     : data-valid strobe to receiver
//   Cclear : one-cycle clear pulse before each transfer
// master is the arbiter's view, slave is the requester/receiver view.
// ---------------------------------------------------------------------------
interface send_arbiter_if
  import send_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]       req;
  logic [SYM_W*NREQ-1:0] sym;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       err;
  logic                  busy;
  logic                  ack;
  logic                  bit0;
  logic                  bit1;
  logic                  Dt;
  logic                  Cclear;

  modport master (
    input  req, sym, ack,
    output gnt, done, err, busy, bit0, bit1, Dt, Cclear
  );

  modport slave (
    output req, sym, ack,
    input  gnt, done, err, busy, bit0, bit1, Dt, Cclear
  );

endinterface

// File: rtl/send_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector.
//   req : request vector
//   ptr : index that has highest priority this round
//   any : at least one request is set
//   idx : first set request scanning ptr, ptr+1, ... with wrap
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] cand;

  // Walk the candidates from furthest to nearest so the one closest to ptr
  // is the last to overwrite idx and therefore wins.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/send_arbiter.sv
// ---------------------------------------------------------------------------
// send_arbiter
// Shares one 2-bit send channel between NREQ requesters. Each granted
// transfer runs CLEAR -> SETUP -> SEND -> RELEASE -> DONE, or drops into
// ABORT when the receiver does not answer within TIMEOUT cycles.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : send_arbiter_if master modport (requesters + receiver channel)
// Every output is decoded from registered state only, so ack never reaches
// an output combinationally.
// ---------------------------------------------------------------------------
module send_arbiter
  import send_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  send_arbiter_if.master       bus
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [PW-1:0]    gidx, gidx_n;
  logic [SYM_W-1:0] symreg, symreg_n;
  logic [TW-1:0]    timer, timer_n;

  logic             pick_any;
  logic [PW-1:0]    pick_idx;

  logic [NREQ-1:0]  gidx_oh;
  logic             in_xfer;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // State register plus the datapath registers the sequencer carries along.
  // Reset drops whatever transfer was in flight without any done/err pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gidx   <= '0;
      symreg <= '0;
      timer  <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gidx   <= gidx_n;
      symreg <= symreg_n;
      timer  <= timer_n;
    end
  end

  // Next-state logic. The symbol is copied once at grant time, so later
  // changes on sym or req cannot disturb a running transfer. The timer is
  // shared by SEND and RELEASE and restarts on entry to each.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    gidx_n   = gidx;
    symreg_n = symreg;
    timer_n  = timer;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gidx_n = pick_idx;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == PW'(i)) symreg_n = bus.sym[i*SYM_W +: SYM_W];
          end
          state_n = CLEAR;
        end
      end
      CLEAR: state_n = SETUP;
      SETUP: begin
        timer_n = '0;
        state_n = SEND;
      end
      SEND: begin
        if (bus.ack) begin
          timer_n = '0;
          state_n = RELEASE;
        end else if (timer == TMAX) begin
          state_n = ABORT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      RELEASE: begin
        if (!bus.ack) begin
          state_n = DONE;
        end else if (timer == TMAX) begin
          state_n = ABORT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DONE, ABORT: begin
        ptr_n   = PW'(next_ptr(int'(gidx), NREQ));
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode: grant and symbol are only presented from CLEAR through
  // RELEASE; completion and abort pulses come straight from their states.
  assign gidx_oh = NREQ'(1) << gidx;
  assign in_xfer = (state == CLEAR) || (state == SETUP) ||
                   (state == SEND)  || (state == RELEASE);

  assign bus.gnt    = in_xfer ? gidx_oh : '0;
  assign bus.done   = (state == DONE)  ? gidx_oh : '0;
  assign bus.err    = (state == ABORT) ? gidx_oh : '0;
  assign bus.busy   = (state != IDLE);
  assign bus.bit0   = in_xfer & symreg[0];
  assign bus.bit1   = in_xfer & symreg[1];
  assign bus.Dt     = (state == SEND);
  assign bus.Cclear = (state == CLEAR);

endmodule

// File: tb/tb_send_arbiter.sv
// ---------------------------------------------------------------------------
// tb_send_arbiter
// Directed bench for send_arbiter with NREQ=4, TIMEOUT=16. Outputs are
// sampled 1 time unit after each rising edge; "cycle n" below means the
// state visible after edge n.
// ---------------------------------------------------------------------------
module tb_send_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;

  int checks;
  int passed;
  int failed;

  send_arbiter_if #(.NREQ(NREQ)) bus ();

  send_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] s,
                               input logic a);
    bus.req = r;
    bus.sym = s;
    bus.ack = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%05h expected=%05h", tag, observed, expected);
    end
  endtask

  // Packs all outputs as {gnt, done, err, busy, bit1, bit0, Dt, Cclear}.
  task automatic checkAll(input string tag, input logic [3:0] egnt,
                          input logic [3:0] edone, input logic [3:0] eerr,
                          input logic ebusy, input logic [1:0] ebits,
                          input logic edt, input logic ecc);
    logic [16:0] obs;
    logic [16:0] exp;
    obs = {bus.gnt, bus.done, bus.err, bus.busy, bus.bit1, bus.bit0,
           bus.Dt, bus.Cclear};
    exp = {egnt, edone, eerr, ebusy, ebits, edt, ecc};
    checkOutput(tag, {15'd0, obs}, {15'd0, exp});
  endtask

  // One prompt-ack transfer starting from an IDLE cycle with req already set.
  task automatic runTransfer(input int idx, input logic [1:0] b);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    tick(); checkAll("rr clear",   oh, 4'h0, 4'h0, 1'b1, b,     1'b0, 1'b1);
    tick(); checkAll("rr setup",   oh, 4'h0, 4'h0, 1'b1, b,     1'b0, 1'b0);
    tick(); checkAll("rr send",    oh, 4'h0, 4'h0, 1'b1, b,     1'b1, 1'b0);
    bus.ack = 1'b1;
    tick(); checkAll("rr release", oh, 4'h0, 4'h0, 1'b1, b,     1'b0, 1'b0);
    bus.ack = 1'b0;
    tick(); checkAll("rr done",    4'h0, oh, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0);
    tick(); checkAll("rr idle",    4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    failed = 0;
    applyStimulus(4'b0000, 8'h00, 1'b0);
    reset = 1'b1;

    // Reset state, including a request that must be ignored while in reset.
    #12;
    checkAll("reset", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'b0001, 8'h02, 1'b1);
    tick();
    checkAll("reset hold", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'b0000, 8'h00, 1'b0);
    reset = 1'b0;
    tick();
    checkAll("idle", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Single transfer on requester 0, symbol 10; req drops after grant.
    applyStimulus(4'b0001, 8'h02, 1'b0);
    tick(); checkAll("t1 clear",   4'h1, 4'h0, 4'h0, 1'b1, 2'b10, 1'b0, 1'b1);
    applyStimulus(4'b0000, 8'h02, 1'b0);
    tick(); checkAll("t1 setup",   4'h1, 4'h0, 4'h0, 1'b1, 2'b10, 1'b0, 1'b0);
    tick(); checkAll("t1 send",    4'h1, 4'h0, 4'h0, 1'b1, 2'b10, 1'b1, 1'b0);
    bus.ack = 1'b1;
    tick(); checkAll("t1 release", 4'h1, 4'h0, 4'h0, 1'b1, 2'b10, 1'b0, 1'b0);
    bus.ack = 1'b0;
    tick(); checkAll("t1 done",    4'h0, 4'h1, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0);
    tick(); checkAll("t1 idle",    4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Requester 1, symbol 01; sym changes and req drops during SEND.
    applyStimulus(4'b0010, 8'h04, 1'b0);
    tick(); checkAll("t6 clear",   4'h2, 4'h0, 4'h0, 1'b1, 2'b01, 1'b0, 1'b1);
    tick(); checkAll("t6 setup",   4'h2, 4'h0, 4'h0, 1'b1, 2'b01, 1'b0, 1'b0);
    tick(); checkAll("t6 send",    4'h2, 4'h0, 4'h0, 1'b1, 2'b01, 1'b1, 1'b0);
    applyStimulus(4'b0000, 8'h08, 1'b1);
    tick(); checkAll("t6 release", 4'h2, 4'h0, 4'h0, 1'b1, 2'b01, 1'b0, 1'b0);
    bus.ack = 1'b0;
    tick(); checkAll("t6 done",    4'h0, 4'h2, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0);
    tick(); checkAll("t6 idle",    4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Requester 2, symbol 11, no ack: 16 SEND cycles then abort.
    applyStimulus(4'b0100, 8'h30, 1'b0);
    tick(); checkAll("t3 clear",   4'h4, 4'h0, 4'h0, 1'b1, 2'b11, 1'b0, 1'b1);
    applyStimulus(4'b0000, 8'h30, 1'b0);
    tick(); checkAll("t3 setup",   4'h4, 4'h0, 4'h0, 1'b1, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      tick(); checkAll("t3 send",  4'h4, 4'h0, 4'h0, 1'b1, 2'b11, 1'b1, 1'b0);
    end
    tick(); checkAll("t3 abort",   4'h0, 4'h0, 4'h4, 1'b1, 2'b00, 1'b0, 1'b0);
    tick(); checkAll("t3 idle",    4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);

    // All four requesting: after the abort on 2 the pointer sits at 3,
    // so the order is 3,0,1,2,3,0 with wraps from 3 to 0.
    applyStimulus(4'b1111, 8'hE4, 1'b0);
    runTransfer(3, 2'b11);
    runTransfer(0, 2'b00);
    runTransfer(1, 2'b01);
    runTransfer(2, 2'b10);
    runTransfer(3, 2'b11);
    runTransfer(0, 2'b00);
    applyStimulus(4'b0000, 8'hE4, 1'b0);

    // ack stuck high from IDLE on: SEND lasts one cycle, RELEASE times out.
    applyStimulus(4'b0100, 8'hE4, 1'b1);
    tick(); checkAll("t4 clear",   4'h4, 4'h0, 4'h0, 1'b1, 2'b10, 1'b0, 1'b1);
    bus.req = 4'b0000;
    tick(); checkAll("t4 setup",   4'h4, 4'h0, 4'h0, 1'b1, 2'b10, 1'b0, 1'b0);
    tick(); checkAll("t4 send",    4'h4, 4'h0, 4'h0, 1'b1, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      tick(); checkAll("t4 release", 4'h4, 4'h0, 4'h0, 1'b1, 2'b10, 1'b0, 1'b0);
    end
    tick(); checkAll("t4 abort",   4'h0, 4'h0, 4'h4, 1'b1, 2'b00, 1'b0, 1'b0);
    bus.ack = 1'b0;
    tick(); checkAll("t4 idle",    4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Requester 3 interrupted by reset mid-SEND.
    applyStimulus(4'b1000, 8'hE4, 1'b0);
    tick(); checkAll("t5 clear",   4'h8, 4'h0, 4'h0, 1'b1, 2'b11, 1'b0, 1'b1);
    bus.req = 4'b0000;
    tick(); checkAll("t5 setup",   4'h8, 4'h0, 4'h0, 1'b1, 2'b11, 1'b0, 1'b0);
    tick(); checkAll("t5 send",    4'h8, 4'h0, 4'h0, 1'b1, 2'b11, 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1 checkAll("t5 async reset", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(); checkAll("t5 in reset", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    tick(); checkAll("t5 after reset", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Pointer restarted at 0, so requester 1 beats requester 3.
    applyStimulus(4'b1010, 8'hE4, 1'b0);
    runTransfer(1, 2'b01);
    applyStimulus(4'b0000, 8'h00, 1'b0);
    tick(); checkAll("final idle", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/send_arbiter.md
Name: send_arbiter

Overview:
- Clocked controller that shares one 2-bit send channel between NREQ requesters.
- Drives the channel signals bit0, bit1, Dt and Cclear, and handshakes with the receiver on ack.
- Arbitration is round-robin. Each transfer is sequenced as clear, setup, strobe and release, with a timeout abort.
- Sits between the local requesters and the asynchronous receive-side state machine. It replaces ad-hoc per-requester drive of the channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, maximum cycles spent waiting in SEND or RELEASE before abort (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester transfer request, level.
- sym  input  2*NREQ  per-requester symbol; sym[2i+1:2i] belongs to requester i.
- gnt  output  NREQ  one-hot grant, held for the whole transfer.
- done  output  NREQ  one-cycle pulse, successful completion for requester i.
- err  output  NREQ  one-cycle pulse, timeout abort for requester i.
- busy  output  1  high whenever state != IDLE.
- ack  input  1  receiver acknowledge; treated as synchronous to clk.
- bit0  output  1  channel symbol LSB.
- bit1  output  1  channel symbol MSB.
- Dt  output  1  data-valid strobe to receiver.
- Cclear  output  1  one-cycle clear pulse to receiver before each transfer.

Behaviour:
- Reset (async, any state):
  - state=IDLE, ptr=0, gidx=0, timer=0.
  - gnt, done, err, busy, bit0, bit1, Dt, Cclear all 0.
  - A transfer in flight is dropped silently, with no done or err.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... with wrap.
  - Latch gidx and sym[gidx] into symreg, then go to CLEAR.
  - Otherwise remain in IDLE.
- CLEAR (1 cycle): Cclear=1; {bit1,bit0}=symreg; gnt[gidx]=1.
- SETUP (1 cycle): Cclear=0; symbol stable; Dt=0; timer cleared.
- SEND:
  - Dt=1.
  - If ack=1, go to RELEASE and clear timer.
  - Else if timer==TIMEOUT-1, go to ABORT.
  - Else timer++.
- RELEASE:
  - Dt=0; symbol still driven.
  - If ack=0, go to DONE.
  - Else if timer==TIMEOUT-1, go to ABORT.
  - Else timer++.
- DONE (1 cycle): done[gidx]=1; gnt=0; bits=0; ptr=(gidx+1) mod NREQ; go to IDLE.
- ABORT (1 cycle): err[gidx]=1; gnt=0; Dt=0; bits=0; ptr=(gidx+1) mod NREQ; go to IDLE.
- gnt[gidx] is high from CLEAR through RELEASE inclusive.
- bit1/bit0 are 0 outside CLEAR..RELEASE.
- All outputs are registered, or decoded from the state register only; no ack-to-output combinational path.
- Latency:
  - req sampled high at edge 0 gives CLEAR in cycle 1, SETUP in cycle 2, Dt high from cycle 3.
  - With ack high at the end of cycle 3 and low at the end of cycle 4, done pulses in cycle 5 and IDLE is reached in cycle 6.
  - Minimum transfer is 5 busy cycles.
- Boundary conditions:
  - req deasserted after grant: ignored; the transfer completes. The symbol is the latched copy, so later changes to sym are ignored.
  - ack high while in IDLE, CLEAR or SETUP: ignored. The SEND entry check samples ack fresh, so a stuck-high ack completes SEND in one cycle and then times out in RELEASE.
  - Simultaneous requests: only one is granted; the others wait. Fairness: every pending requester is granted within NREQ transfers.
  - ptr wraps NREQ-1 -> 0.
  - timer width is clog2(TIMEOUT); it never exceeds TIMEOUT-1.

Decomposition:
- Package send_pkg:
  - state enum IDLE, CLEAR, SETUP, SEND, RELEASE, DONE, ABORT (3-bit encoding).
  - SYM_W=2.
  - function next_ptr.
- Sub-module rr_pick:
  - Combinational round-robin selector.
  - Inputs req and ptr; outputs any and idx.
  - Instantiated once.
- FSM, timer and output registers live in send_arbiter.

Test Plan:
- Single req[0]=1, sym[1:0]=2'b10; ack rises 1 cycle after Dt and falls 1 cycle after Dt drops -> Cclear pulses in cycle 1, {bit1,bit0}=10 in cycles 1-4, Dt high in cycle 3, done[0] in cycle 5, busy low in cycle 6.
- req=4'b1111 held with ack responding promptly -> grant order 0,1,2,3,0; each done pulse matches its gnt index.
- req[2]=1 and ack never asserted, TIMEOUT=16 -> Dt high for exactly 16 cycles, then err[2] pulse, Dt=0, ptr=3, done never asserted.
- ack stuck high after the first transfer -> the next transfer passes SEND in 1 cycle, then RELEASE times out after 16 cycles -> err pulse.
- reset asserted mid-SEND -> Dt, gnt and bits go to 0 immediately (async); no done or err; after release, the next grant starts at requester 0.
- sym[gidx] changed and req dropped during SEND -> channel bits keep the latched value and done still pulses.
